// File: rtl/key_cmd_scheduler.sv
// Turns four debounced button levels into one prioritised command stream.
// Each button has press-edge detection, hold-to-repeat and a one-deep pending flag.
module key_cmd_scheduler #(
  parameter int unsigned DELAY_CYCLES  = 20_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter logic [3:0]  REPEAT_MASK   = 4'b1110,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_level,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  input  logic       cmd_ready
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HELD
  } btn_st_t;

  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LD = CNT_W'(REPEAT_CYCLES - 1);

  btn_st_t                     state     [4];
  btn_st_t                     state_nxt [4];
  logic [3:0][CNT_W-1:0]       timer;
  logic [3:0][CNT_W-1:0]       timer_nxt;
  logic [3:0]                  prev;
  logic [3:0]                  pending;
  logic [3:0]                  pending_nxt;
  logic [3:0]                  evt;
  logic [3:0]                  grant;
  logic [1:0]                  grant_code;
  logic                        load;

  always_comb begin
    evt = '0;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      timer_nxt[i] = timer[i];
      unique case (state[i])
        IDLE: begin
          if (btn_level[i] & ~prev[i]) begin
            evt[i] = 1'b1;
            if (REPEAT_MASK[i]) begin
              state_nxt[i] = DELAY;
              timer_nxt[i] = DLY_LD;
            end else begin
              state_nxt[i] = HELD;
            end
          end
        end
        DELAY, REPEAT: begin
          if (!btn_level[i]) begin
            state_nxt[i] = IDLE;
          end else if (timer[i] == '0) begin
            evt[i]       = 1'b1;
            state_nxt[i] = REPEAT;
            timer_nxt[i] = RPT_LD;
          end else begin
            timer_nxt[i] = timer[i] - CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_level[i]) state_nxt[i] = IDLE;
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Lowest index wins: scan downward so rotate overwrites the rest.
  always_comb begin
    grant      = '0;
    grant_code = '0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        grant      = 4'(1 << i);
        grant_code = 2'(i);
      end
    end
  end

  assign load = ~cmd_valid | cmd_ready;

  // A fresh event always survives, even when the old request is granted.
  always_comb begin
    pending_nxt = evt | (pending & btn_level & ~(load ? grant : 4'b0000));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) state[i] <= IDLE;
      timer     <= '0;
      prev      <= 4'b1111;
      pending   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) state[i] <= state_nxt[i];
      timer   <= timer_nxt;
      prev    <= btn_level;
      pending <= pending_nxt;
      if (load) begin
        cmd_valid <= |pending;
        if (|pending) cmd_code <= grant_code;
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: transfer scoreboard plus a per-cycle vector
// table for the stalled priority sequence.
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_level;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int cyc;
    int code;
  } xfer_t;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       vld;
    logic [1:0] code;
  } vec_t;

  xfer_t exp_q[$];
  vec_t  tbl[11];

  key_cmd_scheduler #(
    .DELAY_CYCLES (8),
    .REPEAT_CYCLES(4),
    .REPEAT_MASK  (4'b1110),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_level(btn_level),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int code);
    xfer_t e;
    e.cyc  = c;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL xfer_unexpected: got code %0d at cyc %0d, required none",
                 cmd_code, cyc);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        chk("xfer_cyc", cyc, e.cyc);
        chk("xfer_code", int'(cmd_code), e.code);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p;

    tbl[0]  = '{4'b0111, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0111, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'b0111, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{4'b0111, 1'b0, 1'b1, 2'd0};
    tbl[4]  = '{4'b0111, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{4'b0111, 1'b0, 1'b1, 2'd0};
    tbl[6]  = '{4'b0111, 1'b1, 1'b1, 2'd0};
    tbl[7]  = '{4'b0111, 1'b1, 1'b1, 2'd1};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 2'd0};

    // Reset with left held: no edge afterwards until it is re-pressed.
    rst       = 1'b1;
    btn_level = 4'b0010;
    cmd_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", int'(cmd_valid), 0);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_valid", int'(cmd_valid), 0);
    end
    step();
    btn_level = 4'b0000;
    repeat (2) step();

    // Single left press, 3 cycles.
    step();
    btn_level = 4'b0010;
    p = cyc;
    push(p + 2, 1);
    repeat (3) step();
    btn_level = 4'b0000;
    repeat (8) step();
    drain("single_left_done");

    // Down held 20 cycles: press edge plus three repeats.
    step();
    btn_level = 4'b1000;
    p = cyc;
    push(p + 2, 3);
    push(p + 10, 3);
    push(p + 14, 3);
    push(p + 18, 3);
    repeat (20) step();
    btn_level = 4'b0000;
    repeat (6) step();
    drain("down_repeat_done");

    // Rotate held 20 cycles: never repeats.
    step();
    btn_level = 4'b0001;
    p = cyc;
    push(p + 2, 0);
    repeat (20) step();
    btn_level = 4'b0000;
    repeat (6) step();
    drain("rotate_hold_done");

    // Simultaneous rotate/left/right while stalled.
    step();
    p = cyc;
    push(p + 6, 0);
    push(p + 7, 1);
    push(p + 8, 2);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) step();
      btn_level = tbl[k].btn;
      cmd_ready = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("prio_valid_%0d", k), int'(cmd_valid), int'(tbl[k].vld));
      if (tbl[k].vld) begin
        chk($sformatf("prio_code_%0d", k), int'(cmd_code), int'(tbl[k].code));
      end
    end
    repeat (4) step();
    drain("prio_done");

    // Right pressed and released while down is stalled: right is dropped.
    step();
    cmd_ready = 1'b0;
    btn_level = 4'b1000;
    p = cyc;
    push(p + 7, 3);
    repeat (3) step();
    btn_level = 4'b1100;
    repeat (2) step();
    btn_level = 4'b0000;
    @(negedge clk);
    chk("stall_valid", int'(cmd_valid), 1);
    chk("stall_code", int'(cmd_code), 3);
    repeat (2) step();
    cmd_ready = 1'b1;
    repeat (8) step();
    drain("release_done");

    // Reset while a command is loaded and left is still pending.
    step();
    cmd_ready = 1'b0;
    btn_level = 4'b0011;
    repeat (3) step();
    @(negedge clk);
    chk("pre_rst_valid", int'(cmd_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(cmd_valid), 0);
    cmd_ready = 1'b1;
    repeat (15) step();
    @(negedge clk);
    chk("after_rst_valid", int'(cmd_valid), 0);
    btn_level = 4'b0000;
    repeat (3) step();
    drain("mid_rst_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cmd_scheduler.md
# key_cmd_scheduler

Sequences the four debounced button levels (rotate, left, right, down) into a single stream of game commands for the tetris control logic. Each button gets press-edge detection and a hold-to-repeat timer. Simultaneous requests are arbitrated by fixed priority. Exactly one command at a time is presented on a valid/ready handshake. The block sits between the per-button debouncer instances and the game state machine.

## Interface
- DELAY_CYCLES, 20_000_000: cycles from the press edge to the first auto-repeat (200 ms at 100 MHz); must be ≥2.
- REPEAT_CYCLES, 5_000_000: cycles between subsequent auto-repeats (50 ms); must be ≥2.
- REPEAT_MASK, 4'b1110: bit i = 1 enables auto-repeat for button i; rotate (bit 0) does not repeat by default.
- CNT_W, 25: width of each per-button timer; must hold max(DELAY_CYCLES, REPEAT_CYCLES)-1.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_level  input  4  debounced levels; bit0 rotate, bit1 left, bit2 right, bit3 down; 1 = pressed.
- cmd_valid  output  1  command available.
- cmd_code  output  2  0 rotate, 1 left, 2 right, 3 down; only meaningful while cmd_valid = 1.
- cmd_ready  input  1  consumer accepts the command this cycle.

## Operation
- Per button i: prev_i register, press edge e_i = btn_level[i] & ~prev_i.
- Per-button FSM:
  - IDLE: on e_i, go to DELAY and load timer = DELAY_CYCLES-1 (only if REPEAT_MASK[i]; otherwise go to HELD).
  - DELAY/REPEAT: if btn_level[i] = 0, go to IDLE. Otherwise, when timer = 0, emit a repeat event, load timer = REPEAT_CYCLES-1 and go to REPEAT; else decrement the timer.
  - HELD: return to IDLE when the level drops.
- Event (press edge or repeat) sets pending[i].
- If pending[i] is already set, the new event is coalesced (dropped); no queue depth beyond one per button.
- Release (btn_level[i] = 0) clears pending[i] unless that same cycle's event sets it. A command already loaded into the output register is never withdrawn.
- Output register load condition: load = ~cmd_valid | cmd_ready.
  - On load, take the highest-priority pending bit (rotate > left > right > down): cmd_valid←1, cmd_code←index, clear that pending bit.
  - If no bit is pending on load, cmd_valid←0.
- A set and a clear of the same pending bit in the same cycle: the set wins (the new event is kept, the old one is granted).
- While cmd_valid = 1 and cmd_ready = 0, cmd_code is held stable and pending bits continue to accumulate.
- Timer arithmetic is unsigned CNT_W bits. The timer never underflows: the reload occurs at 0.

## Timing
- Reset (synchronous; takes effect on the clk edge where rst = 1):
  - cmd_valid = 0, cmd_code = 0, pending = 0, all FSMs IDLE, timers = 0.
  - prev = 4'b1111, so a button held through reset yields no edge.
- Reset mid-command drops the outstanding command and all pending events.
- Press latency: btn_level[i] rises and is sampled at edge t. pending[i] is visible after edge t; cmd_valid is visible after edge t+1 when no other command is in the way.
- Repeat: with a continuous hold, repeat events occur DELAY_CYCLES cycles after the edge cycle, then every REPEAT_CYCLES cycles.
- Back-to-back throughput: 1 command per cycle while cmd_ready = 1 and requests are pending.
- Handshake: a transfer occurs on any edge where cmd_valid & cmd_ready. The next command, if pending, appears on the following cycle with no bubble.

## Test plan
Bench parameters: DELAY_CYCLES = 8, REPEAT_CYCLES = 4, CNT_W = 4, clock period 10 ns.

- Reset: hold rst 3 cycles with btn_level = 4'b0010 -> cmd_valid = 0 during and after reset; no command is issued until left is released and pressed again.
- Single press, cmd_ready = 1: pulse left for 3 cycles -> exactly one transfer with cmd_code = 1, cmd_valid rising 2 cycles after the press edge.
- Auto-repeat: hold down for 20 cycles with cmd_ready = 1 -> transfers of code 3 at press+2, press+10, press+14, press+18; hold rotate for 20 cycles -> exactly one code-0 transfer.
- Priority and coalescing: press right, left and rotate in the same cycle with cmd_ready = 0 for 6 cycles, then cmd_ready = 1 -> transfers in order 0, 1, 2 on consecutive cycles; cmd_code stays at 0 while stalled.
- Release clears pending: cmd_ready = 0; issue down (loaded), then press and release right within 3 cycles; raise cmd_ready -> only code 3 transfers; right is discarded.
- Reset mid-operation: pending left and rotate with cmd_valid = 1, assert rst for 1 cycle -> cmd_valid = 0 the next cycle and no further transfers without new edges.
